// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave controller.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } apb_state_t;

    localparam int unsigned APB_MAX_WAIT = 15;
    localparam int unsigned APB_CNT_W    = $clog2(APB_MAX_WAIT + 1);

endpackage

// File: rtl/apb_wait_cnt.sv
// Wait-state down-counter: loadable, decrements toward zero, flags zero.
module apb_wait_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_ctrl.sv
// APB slave front-end driving a simple register-bank strobe interface.
// Define APB_PSLVERR_EN to flag unmapped accesses on PSLVERR.
module apb_slave_ctrl
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata
);

    // Out-of-range WAIT_CYCLES saturates at the counter's capacity.
    localparam int unsigned WaitClamp =
        (WAIT_CYCLES > APB_MAX_WAIT) ? APB_MAX_WAIT : WAIT_CYCLES;
    localparam logic [APB_CNT_W-1:0] WaitLoad   = APB_CNT_W'(WaitClamp);
    localparam logic [ADDR_W:0]      NumRegsLim = (ADDR_W + 1)'(NUM_REGS);

    apb_state_t state_q, state_d;

    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic                 write_q;
    logic                 capture;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic [APB_CNT_W-1:0] cnt_val;
    logic                 cnt_zero;
    logic                 in_ready;
    logic                 access;
    logic                 mapped;

    apb_wait_cnt #(
        .WIDTH(APB_CNT_W)
    ) u_wait_cnt (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .load    (cnt_load),
        .load_val(WaitLoad),
        .dec     (cnt_dec),
        .count   (cnt_val),
        .zero    (cnt_zero)
    );

    assign access = PSEL && PENABLE;

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    capture  = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = (WaitLoad != '0) ? WAIT : READY;
                end
            end
            WAIT: begin
                if (access) begin
                    cnt_dec = 1'b1;
                    if (cnt_zero || (cnt_val == APB_CNT_W'(1))) begin
                        state_d = READY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            // Completion and abort both return to IDLE; a following setup phase
            // is captured there, giving back-to-back transfers with no gap.
            READY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= PADDR;
                wdata_q <= PWDATA;
                write_q <= PWRITE;
            end
        end
    end

    assign in_ready  = (state_q == READY);
    assign mapped    = ({1'b0, addr_q} < NumRegsLim);

    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign PREADY    = in_ready;
    assign reg_wr_en = in_ready && access && write_q && mapped;
    assign reg_rd_en = in_ready && access && !write_q && mapped;
    assign PRDATA    = (in_ready && !write_q && mapped) ? reg_rdata : '0;

`ifdef APB_PSLVERR_EN
    assign PSLVERR = in_ready && !mapped;
`else
    assign PSLVERR = 1'b0;
`endif

endmodule
